// File: rtl/offnariscv_pkg.sv
`default_nettype none
// ============================================================================
// offnariscv_pkg : ACE snoop codes, CRRESP layout and snoop decision function
// Revision: 1.0
// ============================================================================
package offnariscv_pkg;

  localparam int LINE_BYTES = 32;

  typedef enum logic [3:0] {
    SNOOP_READ_ONCE              = 4'b0000,
    SNOOP_READ_SHARED            = 4'b0001,
    SNOOP_READ_CLEAN             = 4'b0010,
    SNOOP_READ_NOT_SHARED_DIRTY  = 4'b0011,
    SNOOP_READ_UNIQUE            = 4'b0111,
    SNOOP_CLEAN_SHARED           = 4'b1000,
    SNOOP_CLEAN_INVALID          = 4'b1001,
    SNOOP_MAKE_INVALID           = 4'b1101
  } ace_snoop_e;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } ace_crresp_t;

  typedef struct packed {
    ace_crresp_t crresp;
    logic        upd;
    logic        inv;
    logic        clean;
    logic        shared;
  } snoop_dec_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_DECIDE = 3'd2,
    S_RESP   = 3'd3,
    S_DATA   = 3'd4,
    S_COMMIT = 3'd5
  } snoop_state_e;

  function automatic snoop_dec_t snoop_decide(input logic [3:0] snoop, input logic hit,
                                              input logic dirty, input logic is_unique);
    snoop_dec_t d;
    logic       legal;
    d     = '0;
    legal = 1'b1;
    case (snoop)
      SNOOP_READ_ONCE: begin
        d.crresp.data_transfer = 1'b1;
        d.crresp.is_shared     = 1'b1;
      end
      SNOOP_READ_SHARED, SNOOP_READ_NOT_SHARED_DIRTY: begin
        d.crresp.data_transfer = 1'b1;
        d.crresp.pass_dirty    = dirty;
        d.crresp.is_shared     = 1'b1;
        d.clean                = dirty;
        d.shared               = 1'b1;
      end
      SNOOP_READ_CLEAN: begin
        d.crresp.data_transfer = 1'b1;
        d.crresp.is_shared     = 1'b1;
        d.shared               = 1'b1;
      end
      SNOOP_READ_UNIQUE: begin
        d.crresp.data_transfer = 1'b1;
        d.crresp.pass_dirty    = dirty;
        d.inv                  = 1'b1;
      end
      SNOOP_CLEAN_INVALID: begin
        d.crresp.data_transfer = dirty;
        d.crresp.pass_dirty    = dirty;
        d.inv                  = 1'b1;
      end
      SNOOP_CLEAN_SHARED: begin
        d.crresp.data_transfer = dirty;
        d.crresp.pass_dirty    = dirty;
        d.crresp.is_shared     = 1'b1;
        d.clean                = 1'b1;
        d.shared               = 1'b1;
      end
      SNOOP_MAKE_INVALID: d.inv = 1'b1;
      default: legal = 1'b0;
    endcase
    // Unsupported codes report Error whether or not the line is present
    if (!legal) begin
      d               = '0;
      d.crresp.error  = 1'b1;
    end else if (!hit) begin
      d = '0;
    end else begin
      d.crresp.was_unique = is_unique;
      d.upd               = d.inv | d.clean | d.shared;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/offnariscv_snoop_cd_buf.sv
`default_nettype none
// ============================================================================
// offnariscv_snoop_cd_buf : 2-entry CD beat FIFO that paces data-array reads
// Revision: 1.0
// ============================================================================
module offnariscv_snoop_cd_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     active,
  input  logic [$clog2(BEATS)-1:0] base_idx,
  output logic                     rd_en,
  output logic [$clog2(BEATS)-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     cd_valid,
  input  logic                     cd_ready,
  output logic [DATA_WIDTH-1:0]    cd_data,
  output logic                     cd_last,
  output logic                     done
);
  localparam int               C_IDX_W = $clog2(BEATS);
  localparam logic [C_IDX_W:0] C_BEATS = (C_IDX_W+1)'(BEATS);
  localparam logic [C_IDX_W:0] C_LAST  = (C_IDX_W+1)'(BEATS-1);

  logic [C_IDX_W:0]      r_issued;
  logic [C_IDX_W:0]      r_sent;
  logic                  r_inflight;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [1:0]            w_after;
  logic                  w_pop;

  assign cd_valid = (r_count != 2'd0);
  assign w_pop    = cd_valid & cd_ready;
  // Occupancy once the returning word lands and the head beat leaves
  assign w_after  = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign rd_en    = active && (r_issued < C_BEATS) && (w_after < 2'd2);
  assign rd_idx   = base_idx + r_issued[C_IDX_W-1:0];
  assign cd_data  = cd_valid ? r_mem[r_rd_ptr] : '0;
  assign cd_last  = cd_valid && (r_sent == C_LAST);
  assign done     = w_pop && cd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else if (!active) begin
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= rd_en;
      if (rd_en) r_issued <= r_issued + 1'b1;
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_sent   <= r_sent + 1'b1;
      end
      r_count <= w_after;
    end
  end

  always_ff @(posedge clk) begin
    if (r_inflight) r_mem[r_wr_ptr] <= rd_data;
  end

endmodule
`default_nettype wire

// File: rtl/offnariscv_snoop_responder.sv
`default_nettype none
// ============================================================================
// offnariscv_snoop_responder : ACE AC/CR/CD snoop responder for the L1 D-cache
// Revision: 1.0
// ============================================================================
module offnariscv_snoop_responder
  import offnariscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       ac_valid,
  output logic                                       ac_ready,
  input  logic [ADDR_WIDTH-1:0]                      ac_addr,
  input  logic [3:0]                                 ac_snoop,
  input  logic [2:0]                                 ac_prot,
  output logic                                       cr_valid,
  input  logic                                       cr_ready,
  output logic [4:0]                                 cr_resp,
  output logic                                       cd_valid,
  input  logic                                       cd_ready,
  output logic [DATA_WIDTH-1:0]                      cd_data,
  output logic                                       cd_last,
  output logic                                       lk_req,
  input  logic                                       lk_gnt,
  output logic [ADDR_WIDTH-1:0]                      lk_addr,
  input  logic                                       lk_hit,
  input  logic                                       lk_dirty,
  input  logic                                       lk_unique,
  output logic                                       rd_en,
  output logic [$clog2(LINE_BYTES*8/DATA_WIDTH)-1:0] rd_idx,
  input  logic [DATA_WIDTH-1:0]                      rd_data,
  output logic                                       upd_valid,
  output logic                                       upd_inv,
  output logic                                       upd_clean,
  output logic                                       upd_shared
);
  localparam int                    C_BEATS     = LINE_BYTES*8/DATA_WIDTH;
  localparam int                    C_IDX_W     = $clog2(C_BEATS);
  localparam int                    C_WORD_OFF  = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] C_LINE_MASK = ADDR_WIDTH'(LINE_BYTES-1);

  snoop_state_e          r_state;
  logic                  r_ac_ready;
  logic                  r_lk_req;
  logic                  r_cr_valid;
  ace_crresp_t           r_cr_resp;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_snoop;
  logic                  r_dt;
  logic                  r_upd;
  logic                  r_inv;
  logic                  r_clean;
  logic                  r_shared;
  logic                  r_upd_valid;
  logic                  r_upd_inv;
  logic                  r_upd_clean;
  logic                  r_upd_shared;
  snoop_dec_t            w_dec;
  logic                  w_data_active;
  logic                  w_cd_done;
  logic [C_IDX_W-1:0]    w_base_idx;
  logic                  w_unused;

  assign w_unused      = ^ac_prot;
  assign w_dec         = snoop_decide(r_snoop, lk_hit, lk_dirty, lk_unique);
  assign w_base_idx    = r_addr[C_WORD_OFF +: C_IDX_W];
  assign w_data_active = (r_state == S_DATA);

  assign ac_ready   = r_ac_ready;
  assign lk_req     = r_lk_req;
  assign lk_addr    = r_addr & ~C_LINE_MASK;
  assign cr_valid   = r_cr_valid;
  assign cr_resp    = r_cr_resp;
  assign upd_valid  = r_upd_valid;
  assign upd_inv    = r_upd_inv;
  assign upd_clean  = r_upd_clean;
  assign upd_shared = r_upd_shared;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ac_ready   <= 1'b0;
      r_lk_req     <= 1'b0;
      r_cr_valid   <= 1'b0;
      r_cr_resp    <= '0;
      r_addr       <= '0;
      r_snoop      <= 4'd0;
      r_dt         <= 1'b0;
      r_upd        <= 1'b0;
      r_inv        <= 1'b0;
      r_clean      <= 1'b0;
      r_shared     <= 1'b0;
      r_upd_valid  <= 1'b0;
      r_upd_inv    <= 1'b0;
      r_upd_clean  <= 1'b0;
      r_upd_shared <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ac_ready <= 1'b1;
          if (ac_valid && r_ac_ready) begin
            r_addr     <= ac_addr;
            r_snoop    <= ac_snoop;
            r_ac_ready <= 1'b0;
            r_lk_req   <= 1'b1;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: if (lk_gnt) r_state <= S_DECIDE;
        S_DECIDE: begin
          r_cr_resp  <= w_dec.crresp;
          r_cr_valid <= 1'b1;
          r_dt       <= w_dec.crresp.data_transfer;
          r_upd      <= w_dec.upd;
          r_inv      <= w_dec.inv;
          r_clean    <= w_dec.clean;
          r_shared   <= w_dec.shared;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (cr_ready) begin
            r_cr_valid <= 1'b0;
            r_cr_resp  <= '0;
            if (r_dt) begin
              r_state <= S_DATA;
            end else begin
              r_state      <= S_COMMIT;
              r_upd_valid  <= r_upd;
              r_upd_inv    <= r_inv;
              r_upd_clean  <= r_clean;
              r_upd_shared <= r_shared;
            end
          end
        end
        S_DATA: begin
          if (w_cd_done) begin
            r_state      <= S_COMMIT;
            r_upd_valid  <= r_upd;
            r_upd_inv    <= r_inv;
            r_upd_clean  <= r_clean;
            r_upd_shared <= r_shared;
          end
        end
        S_COMMIT: begin
          // Lock is released together with the commit pulse ending
          r_upd_valid  <= 1'b0;
          r_upd_inv    <= 1'b0;
          r_upd_clean  <= 1'b0;
          r_upd_shared <= 1'b0;
          r_lk_req     <= 1'b0;
          r_ac_ready   <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  offnariscv_snoop_cd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (C_BEATS)
  ) u_cd_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (w_data_active),
    .base_idx (w_base_idx),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .cd_valid (cd_valid),
    .cd_ready (cd_ready),
    .cd_data  (cd_data),
    .cd_last  (cd_last),
    .done     (w_cd_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_offnariscv_snoop_responder.sv
`default_nettype none
// ============================================================================
// tb_offnariscv_snoop_responder : directed + random bench with a snoop model
// Revision: 1.0
// ============================================================================
module tb_offnariscv_snoop_responder;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ac_valid = 1'b0;
  logic          ac_ready;
  logic [AW-1:0] ac_addr = '0;
  logic [3:0]    ac_snoop = '0;
  logic [2:0]    ac_prot = '0;
  logic          cr_valid;
  logic          cr_ready = 1'b0;
  logic [4:0]    cr_resp;
  logic          cd_valid;
  logic          cd_ready = 1'b0;
  logic [DW-1:0] cd_data;
  logic          cd_last;
  logic          lk_req;
  logic          lk_gnt = 1'b0;
  logic [AW-1:0] lk_addr;
  logic          lk_hit = 1'b0;
  logic          lk_dirty = 1'b0;
  logic          lk_unique = 1'b0;
  logic          rd_en;
  logic [2:0]    rd_idx;
  logic [DW-1:0] rd_data = '0;
  logic          upd_valid;
  logic          upd_inv;
  logic          upd_clean;
  logic          upd_shared;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] line_mem [BEATS];

  typedef struct packed {
    logic [4:0] resp;
    logic       dt;
    logic       upd;
    logic       inv;
    logic       clean;
    logic       shared;
  } exp_t;

  always #5 clk = ~clk;

  offnariscv_snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_snoop(ac_snoop), .ac_prot(ac_prot),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data), .cd_last(cd_last),
    .lk_req(lk_req), .lk_gnt(lk_gnt), .lk_addr(lk_addr),
    .lk_hit(lk_hit), .lk_dirty(lk_dirty), .lk_unique(lk_unique),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
    .upd_valid(upd_valid), .upd_inv(upd_inv), .upd_clean(upd_clean), .upd_shared(upd_shared)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic any_output();
    return |{ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last, lk_req, lk_addr,
             rd_en, rd_idx, upd_valid, upd_inv, upd_clean, upd_shared};
  endfunction

  // Snoop outcome from the ACE rule table; resp = {WU,IS,PD,Error,DT}
  function automatic exp_t model(input int code, input bit hit, input bit d, input bit u);
    exp_t e;
    bit   is_read;
    bit   is_clean_op;
    bit   legal;
    e           = '0;
    is_read     = code inside {0, 1, 2, 3, 7};
    is_clean_op = code inside {8, 9};
    legal       = is_read || is_clean_op || (code == 13);
    if (!legal) begin
      e.resp = 5'b00010;
      return e;
    end
    if (!hit) return e;
    e.dt     = is_read || (is_clean_op && d);
    e.resp   = {u, (code inside {0, 1, 2, 3, 8}), d && (code inside {1, 3, 7, 8, 9}), 1'b0, e.dt};
    e.inv    = code inside {7, 9, 13};
    e.shared = code inside {1, 2, 3, 8};
    e.clean  = (code == 8) || (d && (code inside {1, 3}));
    e.upd    = e.inv || e.shared || e.clean;
    return e;
  endfunction

  task automatic run_snoop(input logic [AW-1:0] addr, input logic [3:0] code,
                           input bit hit, input bit dirty, input bit uniq,
                           input int gnt_delay, input int cd_mode, input int cr_mode,
                           input int rst_beat);
    exp_t          e;
    logic [DW-1:0] exp_q [BEATS];
    int            w, cyc, req_cycles, beats, reads;
    int            hold_viol, over_viol, last_viol, stab_viol;
    int            cr_seen, upd_cnt, upd_beats, first_beat, last_beat;
    bit            pend_rd, done, aborted, cr_open;
    logic [2:0]    pend_idx;
    logic [4:0]    cr_val, cr_hold;
    logic [2:0]    upd_flags;
    int            base;

    w = 0; cyc = 0; req_cycles = 0; beats = 0; reads = 0;
    hold_viol = 0; over_viol = 0; last_viol = 0; stab_viol = 0;
    cr_seen = 0; upd_cnt = 0; upd_beats = 0; first_beat = 0; last_beat = 0;
    pend_rd = 0; done = 0; aborted = 0; cr_open = 0;
    pend_idx = '0; cr_val = '0; cr_hold = '0; upd_flags = '0;

    e    = model(int'(code), hit, dirty, uniq);
    base = int'(addr[4:2]);
    for (int k = 0; k < BEATS; k++) line_mem[k] = $urandom;
    for (int k = 0; k < BEATS; k++) exp_q[k] = line_mem[(base + k) % BEATS];

    while (!ac_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ac_ready_idle", ac_ready, 1);
    if (!ac_ready) return;

    lk_hit = hit; lk_dirty = dirty; lk_unique = uniq;
    ac_valid = 1'b1; ac_addr = addr; ac_snoop = code; ac_prot = 3'($urandom);
    @(negedge clk);
    ac_valid = 1'b0;

    while (cyc < 300) begin
      rd_data = pend_rd ? line_mem[pend_idx] : DW'($urandom);
      pend_rd = 0;
      case (cd_mode)
        0:       cd_ready = 1'b1;
        1:       cd_ready = (cyc % 2 == 0);
        default: cd_ready = 1'($urandom);
      endcase
      cr_ready = (cr_mode == 0) ? 1'b1 : 1'($urandom);
      if (lk_req) req_cycles++;
      lk_gnt = lk_req && (req_cycles > gnt_delay);
      #1;
      if (ac_ready) begin
        done = 1;
        break;
      end
      if (rst_beat > 0 && cd_valid && beats == rst_beat - 1) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", any_output(), 0);
        aborted = 1;
        break;
      end
      if (!lk_req) hold_viol++;
      if (cr_valid) begin
        if (!cr_open) begin
          cr_open = 1;
          cr_hold = cr_resp;
        end else if (cr_resp !== cr_hold) begin
          stab_viol++;
        end
        if (cr_ready) begin
          cr_seen++;
          cr_val  = cr_resp;
          cr_open = 0;
        end
      end
      if (upd_valid) begin
        upd_cnt++;
        upd_beats = beats;
        upd_flags = {upd_inv, upd_clean, upd_shared};
      end
      if (cd_valid && cd_ready) begin
        if (beats < BEATS) check("cd_data", cd_data, exp_q[beats]);
        if (cd_last !== (beats == BEATS - 1)) last_viol++;
        if (beats == 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
      end
      if (rd_en) begin
        reads++;
        pend_rd  = 1;
        pend_idx = rd_idx;
      end
      if (reads - beats > 2) over_viol++;
      @(negedge clk);
      cyc++;
    end

    lk_gnt = 1'b0; cd_ready = 1'b0; cr_ready = 1'b0;

    if (aborted) begin
      repeat (2) @(negedge clk);
      check("reset_hold_outs", any_output(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_ac_ready", ac_ready, 1);
      upd_cnt = 0;
      repeat (3) begin
        if (upd_valid || lk_req) upd_cnt++;
        @(negedge clk);
      end
      check("post_reset_quiet", upd_cnt, 0);
      return;
    end

    check("txn_done", done, 1);
    check("lk_req_released", lk_req, 0);
    check("lk_req_held", hold_viol, 0);
    check("cr_handshakes", cr_seen, 1);
    check("cr_resp", cr_val, e.resp);
    check("cr_resp_stable", stab_viol, 0);
    check("cd_beats", beats, e.dt ? BEATS : 0);
    check("cd_last_position", last_viol, 0);
    check("rd_overfill", over_viol, 0);
    check("upd_count", upd_cnt, e.upd ? 1 : 0);
    if (e.upd && upd_cnt == 1) begin
      check("upd_flags", upd_flags, {e.inv, e.clean, e.shared});
      check("upd_after_data", upd_beats, beats);
    end
    if (cd_mode == 0 && e.dt && beats == BEATS)
      check("cd_back_to_back", last_beat - first_beat, BEATS - 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_outs", any_output(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ac_ready", ac_ready, 1);

    // hit dirty unique ReadShared, critical word 3
    run_snoop(32'h0000_100C, 4'b0001, 1, 1, 1, 0, 0, 0, 0);
    // miss ReadUnique
    run_snoop(32'h0000_2040, 4'b0111, 0, 0, 0, 0, 0, 0, 0);
    // hit clean shared MakeInvalid
    run_snoop(32'h0000_3000, 4'b1101, 1, 0, 0, 0, 0, 0, 0);
    // cd_ready toggling, grant held off 5 cycles
    run_snoop(32'h0000_4014, 4'b0111, 1, 1, 0, 5, 1, 0, 0);
    // unsupported code on a hit
    run_snoop(32'h0000_5000, 4'b1111, 1, 1, 1, 0, 0, 0, 0);
    // CleanShared hit dirty, response back-pressure
    run_snoop(32'h0000_601C, 4'b1000, 1, 1, 0, 2, 0, 1, 0);
    // reset while the fourth beat is presented
    run_snoop(32'h0000_7008, 4'b0000, 1, 0, 1, 1, 0, 0, 4);

    for (int t = 0; t < 14; t++) begin
      run_snoop($urandom, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
